// File: rtl/synapse_pkg.sv
// Shared types and constants for the synapse current generator.
// Signed (inhibitory) weights are enabled by defining SYN_INHIBIT_EN.
package synapse_pkg;

  localparam int N_INPUTS_DEF     = 4;
  localparam int DECAY_PERIOD_DEF = 16;
  localparam int DECAY_SHIFT_DEF  = 2;
  localparam int CURRENT_MAX      = 255;

  typedef enum logic {
    S_IDLE,
    S_ADD
  } syn_state_t;

endpackage

// File: rtl/synapse_current_gen_decay_timer.sv
// Free-running decay counter; o_tick pulses for the one cycle
// whose closing edge wraps the count back to zero.
module decay_timer #(
  parameter int PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/synapse_current_gen.sv
// Event-driven synaptic current with per-source weights and decay.
// Define SYN_INHIBIT_EN for signed weights clamped at 0 and 255.
module synapse_current_gen
  import synapse_pkg::*;
#(
  parameter int N_INPUTS     = N_INPUTS_DEF,
  parameter int DECAY_PERIOD = DECAY_PERIOD_DEF,
  parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ev_valid,
  input  logic [$clog2(N_INPUTS)-1:0] ev_addr,
  output logic                        ev_ready,
  input  logic                        wr_en,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr,
  input  logic [7:0]                  wr_data,
  output logic [7:0]                  current,
  output logic                        busy
);

  syn_state_t r_state;
  syn_state_t w_next;
  logic [7:0] r_w [N_INPUTS];
  logic [7:0] r_lat;
  logic [7:0] r_cur;
  logic [7:0] w_dec;
  logic [7:0] w_sat;
  logic       w_tick;
  logic       w_accept;

  decay_timer #(
    .PERIOD (DECAY_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_accept = (r_state == S_IDLE) && ev_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (ev_valid) w_next = S_ADD;
      S_ADD:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_lat samples the pre-edge table, so a same-edge write loses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) r_w[i] <= '0;
      r_lat <= '0;
    end else begin
      if (wr_en) r_w[wr_addr] <= wr_data;
      if (w_accept) r_lat <= r_w[ev_addr];
    end
  end

  assign w_dec = w_tick ? (r_cur - (r_cur >> DECAY_SHIFT)) : r_cur;

`ifdef SYN_INHIBIT_EN
  logic signed [9:0] w_sum;
  assign w_sum = $signed({2'b00, w_dec})
               + $signed({{2{r_lat[7]}}, r_lat});
  always_comb begin
    w_sat = w_sum[7:0];
    if (w_sum < 0) begin
      w_sat = '0;
    end else if (w_sum > 10'sd255) begin
      w_sat = 8'(CURRENT_MAX);
    end
  end
`else
  logic [8:0] w_sum;
  assign w_sum = {1'b0, w_dec} + {1'b0, r_lat};
  assign w_sat = w_sum[8] ? 8'(CURRENT_MAX) : w_sum[7:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur <= '0;
    end else if (r_state == S_ADD) begin
      r_cur <= w_sat;
    end else if (w_tick) begin
      r_cur <= w_dec;
    end
  end

  assign ev_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_ADD);
  assign current  = r_cur;

endmodule

// File: tb/tb_synapse_current_gen.sv
// Scoreboard bench for synapse_current_gen: directed cases plus
// randomized traffic against a cycle-level arithmetic model.
module tb_synapse_current_gen;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int SH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_addr = '0;
  logic       ev_ready;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] current;
  logic       busy;

  always #5 clk = ~clk;

  synapse_current_gen #(
    .N_INPUTS     (N),
    .DECAY_PERIOD (P),
    .DECAY_SHIFT  (SH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_valid (ev_valid),
    .ev_addr  (ev_addr),
    .ev_ready (ev_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .current  (current),
    .busy     (busy)
  );

  typedef struct {
    int cur;
    bit rdy;
    bit bsy;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int         m_cur = 0;
  int         m_pend = 0;
  bit         m_pv = 0;
  int         m_cnt = 0;
  logic [7:0] m_w [N];

  function automatic int wval(input logic [7:0] w);
`ifdef SYN_INHIBIT_EN
    return int'($signed(w));
`else
    return int'(w);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // Reference: per edge, decay if the edge closes a period, add any
  // weight accepted on the previous edge, clamp to 0..255.
  always @(posedge clk) begin
    int   c;
    bit   npv;
    exp_t e;
    if (!rst_n) begin
      m_cur <= 0;
      m_pv  <= 0;
      m_cnt <= 0;
      for (int i = 0; i < N; i++) m_w[i] <= '0;
      e.cur = 0; e.rdy = 1; e.bsy = 0;
      q.push_back(e);
    end else begin
      c = m_cur;
      if (m_cnt == P - 1) c = c - c / (2 ** SH);
      if (m_pv) c = c + m_pend;
      if (c > 255) c = 255;
      if (c < 0) c = 0;
      npv = !m_pv && ev_valid;
      m_pend <= wval(m_w[ev_addr]);
      m_pv   <= npv;
      m_cur  <= c;
      m_cnt  <= (m_cnt + 1) % P;
      if (wr_en) m_w[wr_addr] <= wr_data;
      e.cur = c; e.rdy = !npv; e.bsy = npv;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_current", 32'(current), 32'(e.cur));
      chk("sb_ev_ready", 32'(ev_ready), 32'(e.rdy));
      chk("sb_busy", 32'(busy), 32'(e.bsy));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ev_valid = 1'b0;
    wr_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = 8'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic send(input int a);
    int k = 0;
    while (!ev_ready && k < 8) begin
      step();
      k++;
    end
    if (k == 8) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: ev_ready stuck 0, expected 1");
    end
    ev_valid = 1'b1;
    ev_addr = 2'(a);
    step();
    ev_valid = 1'b0;
    step();
  endtask

  task automatic to_phase(input int k);
    int g = 0;
    while (m_cnt != k && g < 4 * P) begin
      step();
      g++;
    end
  endtask

  initial begin
    do_reset();
    chk("reset_current", 32'(current), 0);
    chk("reset_ready", 32'(ev_ready), 1);
    chk("reset_busy", 32'(busy), 0);

    wr(1, 50);
    ev_valid = 1'b1;
    ev_addr = 2'd1;
    step();
    ev_valid = 1'b0;
    chk("hs_ready_low", 32'(ev_ready), 0);
    chk("hs_busy", 32'(busy), 1);
    chk("hs_cur_hold", 32'(current), 0);
    step();
    chk("hs_ready_back", 32'(ev_ready), 1);
    chk("add_50", 32'(current), 50);

    do_reset();
    wr(0, 100);
    send(0);
    chk("sat_100", 32'(current), 100);
    send(0);
    chk("sat_200", 32'(current), 200);
    send(0);
    chk("sat_255", 32'(current), 255);

    do_reset();
    wr(0, 200);
    send(0);
    chk("decay_pre", 32'(current), 200);
    to_phase(P - 1);
    step();
    chk("decay_150", 32'(current), 150);
    to_phase(P - 1);
    step();
    chk("decay_113", 32'(current), 113);

    do_reset();
    wr(0, 200);
    wr(1, 20);
    send(0);
    to_phase(P - 2);
    ev_valid = 1'b1;
    ev_addr = 2'd1;
    step();
    ev_valid = 1'b0;
    step();
    chk("tick_add_170", 32'(current), 170);

    do_reset();
    wr(2, 5);
    wr_en = 1'b1;
    wr_addr = 2'd2;
    wr_data = 8'd9;
    ev_valid = 1'b1;
    ev_addr = 2'd2;
    step();
    wr_en = 1'b0;
    ev_valid = 1'b0;
    step();
    chk("old_weight_5", 32'(current), 5);
    send(2);
    chk("new_weight_14", 32'(current), 14);

    do_reset();
    wr(0, 100);
    send(0);
    chk("pre_abort", 32'(current), 100);
    ev_valid = 1'b1;
    ev_addr = 2'd0;
    step();
    ev_valid = 1'b0;
    chk("abort_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_current", 32'(current), 0);
    chk("abort_ready", 32'(ev_ready), 1);
    chk("abort_busy_low", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_no_add", 32'(current), 0);
    send(0);
    chk("abort_w_clear", 32'(current), 0);

`ifdef SYN_INHIBIT_EN
    do_reset();
    wr(0, 30);
    wr(1, 8'hEC);
    send(0);
    chk("inh_30", 32'(current), 30);
    send(1);
    chk("inh_10", 32'(current), 10);
    send(1);
    chk("inh_0", 32'(current), 0);
`endif

    do_reset();
    repeat (3000) begin
      ev_valid = 1'($urandom_range(0, 1));
      ev_addr = 2'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom);
      wr_data = $urandom_range(0, 1) ? 8'($urandom_range(0, 40))
                                     : 8'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    ev_valid = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_current_gen.md
SYNAPSE_CURRENT_GEN -- requirements
Module: synapse_current_gen

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of presynaptic addresses (power of two).
REQ-002 SHALL have parameter DECAY_PERIOD, default 16, clocks between decay ticks (>=2).
REQ-003 SHALL have parameter DECAY_SHIFT, default 2, decay amount = current >> DECAY_SHIFT per tick.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port ev_valid, input, 1, spike event present.
REQ-007 SHALL have port ev_addr, input, log2(N_INPUTS), presynaptic source of event.
REQ-008 SHALL have port ev_ready, output, 1, block accepts event this cycle.
REQ-009 SHALL have port wr_en, input, 1, weight-table write strobe.
REQ-010 SHALL have port wr_addr, input, log2(N_INPUTS), weight index to write.
REQ-011 SHALL have port wr_data, input, 8, weight value.
REQ-012 SHALL have port current, output, 8, registered synaptic current driving a neuron current input.
REQ-013 SHALL have port busy, output, 1, high while FSM is in ADD.

Function
REQ-014 SHALL hold N_INPUTS x 8-bit weight registers, written at edge when wr_en=1.
REQ-015 SHALL implement FSM {IDLE, ADD}; ev_ready=1 only in IDLE; busy=1 only in ADD.
REQ-016 SHALL accept event when ev_valid&ev_ready at edge t: latch weight[ev_addr], go ADD.
REQ-017 SHALL, in ADD, update current at edge t+1 and return to IDLE; max throughput one event per 2 clocks.
REQ-018 SHALL use weight value present before edge t if wr_en targets the same address at edge t (old weight wins).
REQ-019 SHALL run free counter 0..DECAY_PERIOD-1; decay tick at wrap to 0.
REQ-020 SHALL on decay tick without add: current <= current - (current >> DECAY_SHIFT).
REQ-021 SHALL on decay tick coinciding with ADD update: decay first, then add weight, in one edge.
REQ-022 SHALL compute add in 9+ bits and saturate result at 255; never wrap.
REQ-023 SHALL leave current unchanged on cycles with neither tick nor ADD update.
REQ-024 SHALL ignore ev_addr/ev_valid while in ADD (no queuing; source holds valid).

Reset
REQ-025 SHALL on rst_n low: current=0, weights all 0, FSM=IDLE, ev_ready=1, busy=0, decay counter=0.
REQ-026 SHALL abandon an in-flight ADD on reset mid-operation; latched weight discarded.

Configuration
REQ-027 SHALL with SYN_INHIBIT_EN defined treat weights as signed two's complement (-128..127) and saturate current at 0 below, 255 above.
REQ-028 SHALL without SYN_INHIBIT_EN treat weights as unsigned 0..255, excitatory only.

Structure
REQ-029 SHALL place FSM state typedef, default parameter constants and CURRENT_MAX=255 in package synapse_pkg.
REQ-030 SHALL implement the decay counter/tick as sub-module decay_timer (output: one-cycle tick pulse).

Verification
REQ-031 SHALL test: weight[1]=50, event addr 1 -> current 0->50 one edge after handshake; ev_ready low exactly one cycle.
REQ-032 SHALL test: weight[0]=100, three events addr 0 -> 100, 200, 255 (saturated, no wrap).
REQ-033 SHALL test: current=200, no events, DECAY_SHIFT=2 -> 150 at next tick, 113 at following tick.
REQ-034 SHALL test: tick coincident with ADD, current=200, weight=20 -> 170.
REQ-035 SHALL test: wr_en to addr 2 (data 9, old 5) same edge as event addr 2 -> current increases by 5; later event adds 9.
REQ-036 SHALL test: SYN_INHIBIT_EN, current=30, weight 0xEC (-20) twice -> 10 then 0; rst_n pulse mid-ADD -> current 0, ev_ready 1.
